// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: sequencer state encoding and byte lane width.
package alu_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/byte_serial_adder_fa8.sv
// 8-bit ripple-carry adder used as the single arithmetic element of the byte-serial sequencer.
module FullAdder8b
    import alu_pkg::*;
(
    input  logic [BYTE_W-1:0] a_in,
    input  logic [BYTE_W-1:0] b_in,
    input  logic              carry_in,
    output logic [BYTE_W-1:0] sum_out,
    output logic              carry_out
);

    logic [BYTE_W:0] w_c;

    // Explicit bitwise ripple chain.
    always_comb begin
        w_c     = '0;
        sum_out = '0;
        w_c[0]  = carry_in;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            sum_out[i] = a_in[i] ^ b_in[i] ^ w_c[i];
            w_c[i+1]   = (a_in[i] & b_in[i]) | (w_c[i] & (a_in[i] ^ b_in[i]));
        end
    end

    assign carry_out = w_c[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// Area-optimised add/subtract: streams WIDTH-bit operands one byte per cycle
// through a single FullAdder8b with a registered inter-byte carry.
module byte_serial_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic             subtract_in,
    input  logic [WIDTH-1:0] operand1_in,
    input  logic [WIDTH-1:0] operand2_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             zero_out
);

    localparam int unsigned NBYTES = WIDTH / BYTE_W;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [WIDTH-1:0]  r_op1;
    logic [WIDTH-1:0]  r_op2;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;
    logic [WIDTH-1:0]  r_result;
    logic              r_busy;
    logic              r_done;
    logic              r_carry_out;
    logic              r_ovf;
    logic              r_zero;

    logic              w_accept;
    logic              w_last;
    logic [BYTE_W-1:0] w_a;
    logic [BYTE_W-1:0] w_b;
    logic [BYTE_W-1:0] w_sum;
    logic              w_co;
    logic [WIDTH-1:0]  w_res_full;

    assign w_accept = start_in && (r_state != ST_RUN);
    assign w_last   = (r_state == ST_RUN) && (r_idx == LAST_IDX);
    assign w_a      = r_op1[BYTE_W * 32'(r_idx) +: BYTE_W];
    assign w_b      = r_op2[BYTE_W * 32'(r_idx) +: BYTE_W];

    FullAdder8b u_fa8 (
        .a_in      (w_a),
        .b_in      (w_b),
        .carry_in  (r_carry),
        .sum_out   (w_sum),
        .carry_out (w_co)
    );

    // Result with the current byte merged in; on the last byte this is the final value.
    always_comb begin
        w_res_full = r_result;
        w_res_full[BYTE_W * 32'(r_idx) +: BYTE_W] = w_sum;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start_in) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)   w_state_next = ST_DONE;
            ST_DONE: w_state_next = start_in ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Operand latch, byte walk and flag capture on the final byte.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_op1       <= '0;
            r_op2       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_op1   <= operand1_in;
            r_op2   <= operand2_in ^ {WIDTH{subtract_in}};
            r_carry <= subtract_in;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_result <= w_res_full;
            r_carry  <= w_co;
            r_idx    <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_carry_out <= w_co;
                r_ovf       <= (r_op1[WIDTH-1] == r_op2[WIDTH-1]) && (w_sum[BYTE_W-1] != r_op1[WIDTH-1]);
                r_zero      <= (w_res_full == '0);
            end
        end
    end

    assign busy_out     = r_busy;
    assign done_out     = r_done;
    assign result_out   = r_result;
    assign carry_out    = r_carry_out;
    assign overflow_out = r_ovf;
    assign zero_out     = r_zero;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed self-checking bench for byte_serial_adder at WIDTH=32 and WIDTH=8.
module tb_byte_serial_adder;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        start, sub;
    logic [31:0] op1, op2;
    logic        busy, done, carry, ovf, zero;
    logic [31:0] result;

    logic        start8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, carry8, ovf8, zero8;
    logic [7:0]  result8;

    int          n_pass  = 0;
    int          n_total = 0;
    bit          both_seen = 1'b0;
    int          n8;
    int          dcount, d1, d2;
    logic [31:0] r1, r2;

    always #5 clk = ~clk;

    byte_serial_adder #(.WIDTH(32)) dut (
        .clk_in(clk), .reset_in(reset_in), .start_in(start), .subtract_in(sub),
        .operand1_in(op1), .operand2_in(op2), .busy_out(busy), .done_out(done),
        .result_out(result), .carry_out(carry), .overflow_out(ovf), .zero_out(zero)
    );

    byte_serial_adder #(.WIDTH(8)) dut8 (
        .clk_in(clk), .reset_in(reset_in), .start_in(start8), .subtract_in(sub8),
        .operand1_in(a8), .operand2_in(b8), .busy_out(busy8), .done_out(done8),
        .result_out(result8), .carry_out(carry8), .overflow_out(ovf8), .zero_out(zero8)
    );

    always @(negedge clk) begin
        if ((busy && done) || (busy8 && done8)) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] er,
                         input logic ec, input logic ev, input logic ez);
        int n;
        @(negedge clk);
        start = 1'b1; sub = s; op1 = a; op2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_carry"}, 64'(carry), 64'(ec));
        check({tag, "_overflow"}, 64'(ovf), 64'(ev));
        check({tag, "_zero"}, 64'(zero), 64'(ez));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_result_held"}, 64'(result), 64'(er));
    endtask

    initial begin
        reset_in = 1'b1;
        start = 1'b0; sub = 1'b0; op1 = '0; op2 = '0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'({carry, ovf, zero}), 64'd0);
        @(negedge clk);
        reset_in = 1'b0;

        run32("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run32("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run32("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Start held high: ops accepted at E0 and E5; operand churn while busy is ignored.
        dcount = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        @(negedge clk);
        start = 1'b1; sub = 1'b0; op1 = 32'h10; op2 = 32'h20;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 1 || k == 6) begin op1 = 32'hDEAD_0000; op2 = 32'h0BAD_0001; end
            if (k == 3 || k == 8) begin op1 = 32'h10; op2 = 32'h20; end
            if (done) begin
                dcount++;
                if (dcount == 1) begin d1 = k; r1 = result; end
                else begin d2 = k; r2 = result; end
            end
        end
        start = 1'b0;
        check("held_done_count", 64'(dcount), 64'd2);
        check("held_first_done", 64'(d1), 64'd4);
        check("held_second_done", 64'(d2), 64'd9);
        check("held_first_result", 64'(r1), 64'h30);
        check("held_second_result", 64'(r2), 64'h30);
        repeat (2) @(posedge clk);
        #1;
        check("held_idle_after", 64'({busy, done}), 64'd0);

        run32("sub_5_7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run32("sub_7_5", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; op1 = 32'h1234_5678; op2 = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrun_busy", 64'(busy), 64'd1);
        #2 reset_in = 1'b1;
        #1;
        check("async_reset_busy_done", 64'({busy, done}), 64'd0);
        check("async_reset_result", 64'(result), 64'd0);
        check("async_reset_flags", 64'({carry, ovf, zero}), 64'd0);
        @(negedge clk);
        reset_in = 1'b0;
        run32("after_reset_3_4", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

        // Single-byte configuration.
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h80; b8 = 8'h80;
        @(posedge clk); #1;
        start8 = 1'b0;
        n8 = 0;
        if (!done8) begin
            check("w8_busy_after_start", 64'(busy8), 64'd1);
            while (!done8 && n8 < 10) begin
                @(posedge clk); #1;
                n8++;
            end
        end
        check("w8_latency", 64'(n8), 64'd1);
        check("w8_result", 64'(result8), 64'h00);
        check("w8_flags_cvz", 64'({carry8, ovf8, zero8}), 64'b111);

        repeat (2) @(posedge clk);
        check("busy_done_never_both", 64'(both_seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
